// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch FSM encoding, reset and exception vectors.
// Also consumed by the CP0 block for its vector selection.
package cpu_defs;

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_ADEL = 3'd4
    } fetch_state_t;

    localparam logic [31:0] RESET_VEC_DEF  = 32'hbfc0_0000;
    localparam logic [31:0] EXC_VEC_BOOT   = 32'hbfc0_0380;
    localparam logic [31:0] EXC_VEC_NORM   = 32'h8000_0180;
    localparam logic [31:0] TLB_REFILL_VEC = 32'h8000_0000;

    function automatic logic word_misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/redirect_latch.sv
// Holds a redirect that arrives while a fetch is in flight.
// Exception flushes outrank branches, both live and pending.
module redirect_latch
    import cpu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic [WIDTH-1:0] flush_pc,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             capture,
    input  logic             clear,
    output logic             pend,
    output logic [WIDTH-1:0] target
);

    logic             pend_flush;
    logic [WIDTH-1:0] addr;
    logic             merged_flush;

    // A live branch never displaces a held flush; a live flush always wins.
    always_comb begin
        target       = addr;
        merged_flush = pend_flush;
        if (flush) begin
            target       = flush_pc;
            merged_flush = 1'b1;
        end else if (br_taken && !pend_flush) begin
            target       = br_target;
            merged_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend       <= 1'b0;
            pend_flush <= 1'b0;
            addr       <= '0;
        end else if (clear) begin
            pend       <= 1'b0;
            pend_flush <= 1'b0;
        end else if (capture && (flush || br_taken)) begin
            pend       <= 1'b1;
            pend_flush <= merged_flush;
            addr       <= target;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and single-outstanding instruction fetch controller.
// Presents one word at a time to decode; redirects drop stale fetches.
module pc_fetch_ctrl
    import cpu_defs::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
    parameter int               INC       = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] flush_pc,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_inst,
    output logic             out_adel
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(INC);

    fetch_state_t     state;
    fetch_state_t     state_n;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] fetch_pc_n;
    logic [WIDTH-1:0] out_pc_n;
    logic [WIDTH-1:0] out_inst_n;
    logic             out_valid_n;
    logic             out_adel_n;
    logic             capture;
    logic             clear;
    logic             redir_pend;
    logic [WIDTH-1:0] redir_target;
    logic             redirect;
    logic             misaligned;

    redirect_latch #(
        .WIDTH(WIDTH)
    ) u_redir (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (flush),
        .flush_pc (flush_pc),
        .br_taken (br_taken),
        .br_target(br_target),
        .capture  (capture),
        .clear    (clear),
        .pend     (redir_pend),
        .target   (redir_target)
    );

    assign redirect   = flush | br_taken | redir_pend;
    assign misaligned = word_misaligned(fetch_pc[1:0]);
    assign inst_addr  = fetch_pc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_BOOT;
            fetch_pc  <= RESET_VEC;
            out_valid <= 1'b0;
            out_adel  <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            out_valid <= out_valid_n;
            out_adel  <= out_adel_n;
            out_pc    <= out_pc_n;
            out_inst  <= out_inst_n;
        end
    end

    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        out_valid_n = out_valid;
        out_adel_n  = out_adel;
        out_pc_n    = out_pc;
        out_inst_n  = out_inst;
        inst_req    = 1'b0;
        capture     = 1'b0;
        clear       = 1'b0;
        unique case (state)
            ST_BOOT: begin
                state_n = ST_REQ;
                if (redirect) begin
                    fetch_pc_n = redir_target;
                    clear      = 1'b1;
                end
            end
            ST_REQ: begin
                if (misaligned) begin
                    // Nothing on the bus yet, so a redirect applies at once.
                    if (redirect) begin
                        fetch_pc_n = redir_target;
                        clear      = 1'b1;
                    end else begin
                        state_n     = ST_ADEL;
                        out_valid_n = 1'b1;
                        out_adel_n  = 1'b1;
                        out_pc_n    = fetch_pc;
                        out_inst_n  = '0;
                    end
                end else begin
                    inst_req = 1'b1;
                    capture  = 1'b1;
                    if (inst_addr_ok) begin
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (inst_data_ok) begin
                    state_n = ST_REQ;
                    if (redirect) begin
                        fetch_pc_n = redir_target;
                        clear      = 1'b1;
                    end else begin
                        state_n     = ST_HOLD;
                        out_valid_n = 1'b1;
                        out_adel_n  = 1'b0;
                        out_pc_n    = fetch_pc;
                        out_inst_n  = inst_rdata;
                        fetch_pc_n  = fetch_pc + STEP;
                    end
                end else begin
                    capture = 1'b1;
                end
            end
            ST_HOLD, ST_ADEL: begin
                if (redirect) begin
                    state_n     = ST_REQ;
                    fetch_pc_n  = redir_target;
                    clear       = 1'b1;
                    out_valid_n = 1'b0;
                    out_adel_n  = 1'b0;
                end else if (!stall) begin
                    state_n     = ST_REQ;
                    out_valid_n = 1'b0;
                    out_adel_n  = 1'b0;
                    if (state == ST_ADEL) begin
                        fetch_pc_n = fetch_pc + STEP;
                    end
                end
            end
            default: begin
                state_n = ST_BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl with a bridge model and
// an architectural next-PC reference for randomized traffic.
`timescale 1ns/1ps
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV  = 32'hbfc0_0000;
    localparam logic [31:0] FPC = 32'hbfc0_0380;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] flush_pc = '0;
    logic [31:0] br_target = '0;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adel;

    int n_tests = 0;
    int n_fail  = 0;

    bit          bus_rand = 1'b0;
    int          fix_delay = 0;
    bit          bus_busy = 1'b0;
    logic [31:0] bus_addr = '0;
    int          bus_delay = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(
        .WIDTH(32),
        .RESET_VEC(RV),
        .INC(4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .stall       (stall),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_adel    (out_adel)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    // Bridge model: one outstanding read, data after bus_delay idle cycles.
    task automatic bus_drive();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'hdead_beef;
        if (bus_busy) begin
            if (bus_delay == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = mem_word(bus_addr);
                bus_busy     = 1'b0;
            end else begin
                bus_delay--;
            end
        end else if (inst_req) begin
            if (!bus_rand || $urandom_range(0, 2) != 0) begin
                inst_addr_ok = 1'b1;
                bus_busy     = 1'b1;
                bus_addr     = inst_addr;
                bus_delay    = bus_rand ? int'($urandom_range(0, 3)) : fix_delay;
            end
        end
    endtask

    task automatic tick();
        bus_drive();
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        br_taken = 1'b0;
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        br_taken = 1'b0;
        bus_busy = 1'b0;
        bus_rand = 1'b0;
        fix_delay = 0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_until_valid(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: out_valid=%b want 1", name, out_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({inst_req, out_valid, out_adel} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_flags: req/valid/adel=%b want 000",
                     {inst_req, out_valid, out_adel});
        end
        n_tests++;
        if (out_pc !== 32'h0 || out_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_data: pc=%h inst=%h want 0 0", out_pc, out_inst);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        n_tests++;
        if (inst_req !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_idle: inst_req=%b want 0", inst_req);
        end
        tick();
        n_tests++;
        if (inst_req !== 1'b1 || inst_addr !== RV) begin
            n_fail++;
            $display("FAIL first_req: req=%b addr=%h want 1 %h", inst_req, inst_addr, RV);
        end
        tick();
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== RV || out_inst !== mem_word(RV)) begin
            n_fail++;
            $display("FAIL first_out: v=%b pc=%h inst=%h want 1 %h %h",
                     out_valid, out_pc, out_inst, RV, mem_word(RV));
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== RV + 32'd4) begin
            n_fail++;
            $display("FAIL second_req: v=%b req=%b addr=%h want 0 1 %h",
                     out_valid, inst_req, inst_addr, RV + 32'd4);
        end
    endtask

    task automatic test_stall();
        logic [31:0] pc0;
        logic [31:0] in0;
        do_reset();
        stall = 1'b1;
        run_until_valid("stall");
        pc0 = out_pc;
        in0 = out_inst;
        n_tests++;
        if (pc0 !== RV || in0 !== mem_word(RV)) begin
            n_fail++;
            $display("FAIL stall_first: pc=%h inst=%h want %h %h", pc0, in0, RV, mem_word(RV));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== pc0 || out_inst !== in0 || inst_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: v=%b pc=%h inst=%h req=%b want 1 %h %h 0",
                         i, out_valid, out_pc, out_inst, inst_req, pc0, in0);
            end
        end
        stall = 1'b0;
        tick();
        n_tests++;
        if (inst_req !== 1'b1 || inst_addr !== RV + 32'd4 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: req=%b addr=%h v=%b want 1 %h 0",
                     inst_req, inst_addr, out_valid, RV + 32'd4);
        end
    endtask

    // k=0 flush+branch together, k=1 flush then branch, k=2 branch then
    // flush, k=3 branch coinciding with address acceptance, k=4 branch in WAIT.
    task automatic test_redirect_capture();
        logic [31:0] exp;
        bit          saw_valid;
        int          n;
        for (int k = 0; k < 5; k++) begin
            do_reset();
            fix_delay = 3;
            flush_pc  = FPC;
            br_target = (k >= 3) ? 32'hbfc0_0100 + 32'(k - 3) * 32'h100 : 32'hbfc0_0100;
            exp = (k >= 3) ? br_target : FPC;
            tick();
            if (k != 3) tick();
            unique case (k)
                0: begin flush = 1'b1; br_taken = 1'b1; tick(); end
                1: begin flush = 1'b1; tick(); br_taken = 1'b1; tick(); end
                2: begin br_taken = 1'b1; tick(); flush = 1'b1; tick(); end
                default: begin br_taken = 1'b1; tick(); end
            endcase
            saw_valid = 1'b0;
            n = 0;
            while (!inst_req && n < 12) begin
                saw_valid |= out_valid;
                tick();
                n++;
            end
            saw_valid |= out_valid;
            n_tests++;
            if (inst_req !== 1'b1 || inst_addr !== exp || saw_valid) begin
                n_fail++;
                $display("FAIL redir_case%0d: req=%b addr=%h dropped=%b want 1 %h 1",
                         k, inst_req, inst_addr, !saw_valid, exp);
            end
            fix_delay = 0;
            run_until_valid("redir_present");
            n_tests++;
            if (out_pc !== exp || out_inst !== mem_word(exp)) begin
                n_fail++;
                $display("FAIL redir_out%0d: pc=%h inst=%h want %h %h",
                         k, out_pc, out_inst, exp, mem_word(exp));
            end
        end
    endtask

    task automatic test_adel();
        do_reset();
        run_until_valid("adel_pre");
        br_taken  = 1'b1;
        br_target = 32'hbfc0_0102;
        tick();
        n_tests++;
        if (inst_req !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL adel_noreq: req=%b v=%b want 0 0", inst_req, out_valid);
        end
        tick();
        n_tests++;
        if ({out_valid, out_adel} !== 2'b11 || out_pc !== 32'hbfc0_0102 || out_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL adel_slot: v/adel=%b pc=%h inst=%h want 11 bfc00102 0",
                     {out_valid, out_adel}, out_pc, out_inst);
        end
        stall = 1'b1;
        tick();
        n_tests++;
        if ({out_valid, out_adel, inst_req} !== 3'b110 || out_pc !== 32'hbfc0_0102) begin
            n_fail++;
            $display("FAIL adel_stall: v/adel/req=%b pc=%h want 110 bfc00102",
                     {out_valid, out_adel, inst_req}, out_pc);
        end
        stall = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({out_valid, out_adel} !== 2'b11 || out_pc !== 32'hbfc0_0106) begin
            n_fail++;
            $display("FAIL adel_retire: v/adel=%b pc=%h want 11 bfc00106",
                     {out_valid, out_adel}, out_pc);
        end
        flush    = 1'b1;
        flush_pc = FPC;
        tick();
        n_tests++;
        if ({inst_req, out_valid, out_adel} !== 3'b100 || inst_addr !== FPC) begin
            n_fail++;
            $display("FAIL adel_flush: req/v/adel=%b addr=%h want 100 %h",
                     {inst_req, out_valid, out_adel}, inst_addr, FPC);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        run_until_valid("rw_pre");
        fix_delay = 3;
        tick();
        tick();
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if ({inst_req, out_valid, out_adel} !== 3'b000 || out_pc !== 32'h0 || out_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL async_clear: req/v/adel=%b pc=%h inst=%h want 000 0 0",
                     {inst_req, out_valid, out_adel}, out_pc, out_inst);
        end
        bus_busy = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hbad0_0bad;
        @(posedge clk);
        @(negedge clk);
        inst_data_ok = 1'b0;
        n_tests++;
        if (inst_req !== 1'b1 || inst_addr !== RV || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL late_data: req=%b addr=%h v=%b want 1 %h 0",
                     inst_req, inst_addr, out_valid, RV);
        end
        fix_delay = 0;
        run_until_valid("rw_post");
        n_tests++;
        if (out_pc !== RV || out_inst !== mem_word(RV)) begin
            n_fail++;
            $display("FAIL restart_out: pc=%h inst=%h want %h %h",
                     out_pc, out_inst, RV, mem_word(RV));
        end
    endtask

    // Architectural model: each retired word is the successor of the last
    // one, unless a redirect intervened, in which case it is the target.
    task automatic test_random();
        logic [31:0] exp;
        logic [31:0] tgt;
        logic [31:0] prev_addr;
        bit          allow;
        bit          prev_pend;
        bit          redir;
        bit          cons;
        int          kind;
        int          consumes;
        do_reset();
        bus_rand  = 1'b1;
        exp       = RV;
        allow     = 1'b1;
        prev_pend = 1'b0;
        prev_addr = '0;
        consumes  = 0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_pend) begin
                n_tests++;
                if (inst_req !== 1'b1 || inst_addr !== prev_addr) begin
                    n_fail++;
                    $display("FAIL addr_stable: req=%b addr=%h want 1 %h",
                             inst_req, inst_addr, prev_addr);
                end
            end
            if (bus_busy && inst_req) begin
                n_tests++;
                n_fail++;
                $display("FAIL one_outstanding: req=%b while busy, want 0", inst_req);
            end
            stall = ($urandom_range(0, 3) == 0);
            cons  = out_valid && !stall;
            redir = allow && ($urandom_range(0, 19) == 0);
            if (redir) begin
                kind      = int'($urandom_range(0, 2));
                flush_pc  = RV + {$urandom_range(0, 1023), 2'b00};
                br_target = RV + {$urandom_range(0, 1023), 2'b00};
                flush     = (kind != 1);
                br_taken  = (kind != 0);
                tgt       = flush ? flush_pc : br_target;
                exp       = tgt;
                allow     = 1'b0;
            end else if (cons) begin
                n_tests++;
                if (out_pc !== exp || out_inst !== mem_word(exp) || out_adel !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_retire: pc=%h inst=%h adel=%b want %h %h 0",
                             out_pc, out_inst, out_adel, exp, mem_word(exp));
                end
                exp   = exp + 32'd4;
                allow = 1'b1;
                consumes++;
            end
            prev_addr = inst_addr;
            prev_pend = inst_req;
            tick();
            prev_pend = prev_pend && !inst_addr_ok;
        end
        stall = 1'b0;
        n_tests++;
        if (consumes < 50) begin
            n_fail++;
            $display("FAIL rand_progress: retired=%0d want >=50", consumes);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_capture();
        test_adel();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Parametrised program-counter and instruction-fetch controller for the MIPS core. It replaces the bare PC register and drives an SRAM-like instruction port with a req/addr_ok/data_ok handshake. It redirects on exceptions and branches, discards in-flight fetches after a redirect, and flags misaligned fetch addresses. It sits between the decode stage and the instruction-side bus bridge.

Parameters:
WIDTH, 32, address and instruction width in bits.
RESET_VEC, 32'hbfc00000, first fetch address after reset.
INC, 4, sequential PC increment in bytes.

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  asynchronous, active-low reset
stall  in  1  decode cannot accept; holds the presented instruction
flush  in  1  exception redirect, one-cycle pulse
flush_pc  in  WIDTH  exception/ERET target, valid with flush
br_taken  in  1  branch/jump redirect, one-cycle pulse
br_target  in  WIDTH  branch target, valid with br_taken
inst_req  out  1  fetch request to bus bridge
inst_addr  out  WIDTH  fetch address, stable while inst_req=1
inst_addr_ok  in  1  address accepted
inst_data_ok  in  1  read data returned
inst_rdata  in  WIDTH  instruction word
out_valid  out  1  instruction presented to decode
out_pc  out  WIDTH  PC of presented instruction
out_inst  out  WIDTH  presented instruction word
out_adel  out  1  presented slot is an address-error fault (misaligned PC)

Behaviour:
- Reset (resetn=0, asynchronous): state=BOOT, fetch_pc=RESET_VEC, redir_pend=0, inst_req=0, out_valid=0, out_adel=0, out_pc=0, out_inst=0.
- States: BOOT, REQ, WAIT, HOLD, ADEL.
- BOOT: inst_req=0 for exactly one cycle after reset release, then REQ. A redirect seen in BOOT loads fetch_pc directly.
- REQ: inst_req=1, inst_addr=fetch_pc. If fetch_pc[1:0]!=0, no request is issued and the state goes to ADEL. On inst_addr_ok, go to WAIT. inst_addr must not change while inst_req=1 and addr_ok=0.
- WAIT: on inst_data_ok, the word is dropped if redir_pend=1 or a flush/br_taken arrives in the same cycle. fetch_pc then loads the redirect address, redir_pend clears, and the state goes to REQ. Otherwise: out_valid=1, out_pc=fetch_pc, out_inst=inst_rdata, fetch_pc+=INC (wraps modulo 2^WIDTH), then HOLD.
- HOLD: outputs stay stable while stall=1. With stall=0 the instruction is consumed that cycle, out_valid drops next cycle and the state returns to REQ. Back-to-back overlap is not supported: at most one outstanding fetch.
- A redirect in HOLD or ADEL drops the presented slot (out_valid=0 next cycle), fetch_pc=redirect address, state goes to REQ.
- ADEL: out_valid=1, out_adel=1, out_pc=fetch_pc, out_inst=0. It holds under stall and is retired like HOLD. The pipeline is expected to raise a flush afterwards. Without one, fetch_pc+=INC.
- Redirect capture in REQ or WAIT: set redir_pend and store the address. Priority is flush > br_taken. A pending flush is never overwritten by a later br_taken. A later flush overwrites a pending branch.
- A redirect in the same cycle as inst_addr_ok in REQ is captured as pending and applied at data return.
- Latency: reset release to first inst_req is 1 cycle. data_ok to out_valid is 1 cycle (registered).

Decomposition:
- Shared package (cpu_defs): state encoding constants, RESET_VEC default, exception vector constants (also used by the CP0 block).
- One sub-module, redirect_latch: redir_pend/redir_addr capture with flush>branch priority and a clear input.

Test Plan:
- Reset release, addr_ok and data_ok each 1 cycle -> inst_req rises 1 cycle after resetn=1 with inst_addr=32'hbfc00000. Then out_pc=bfc00000, then the next request goes to bfc00004.
- stall=1 for 3 cycles while out_valid -> out_pc/out_inst held unchanged and no new inst_req. After release, the next request goes to bfc00004.
- br_taken (target 32'hbfc00100) during WAIT -> the returned word is dropped (out_valid stays 0) and the next inst_addr is bfc00100.
- br_taken and flush (flush_pc=32'hbfc00380) in the same cycle -> the next request goes to bfc00380. Repeat with flush one cycle before the branch -> still bfc00380.
- br_target=32'hbfc00102 -> no inst_req issued, then out_valid=1, out_adel=1, out_pc=bfc00102. A subsequent flush makes the next request go to flush_pc.
- resetn low while in WAIT -> all outputs clear immediately. After release, a late data_ok from the bridge is ignored (BOOT) and the fetch restarts at bfc00000.
